// File: rtl/acc_rd_pkg.sv
// Shared types and helpers for the accelerator read channel.
// Covers the FSM encoding, the line size in bytes and the FIFO pointer width.
package acc_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned line_bytes(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned log2_depth(input int unsigned depth);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(depth)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_rd_line_fifo.sv
// Line buffer for the read channel: synchronous FIFO with registered read data.
// It exposes an occupancy count so the parent can do credit accounting.
module acc_rd_line_fifo
    import acc_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int FIFO_DEPTH = 8,
    localparam int AW = log2_depth(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  empty,
    output logic                  full,
    output logic [AW:0]           count
);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pop_data <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                pop_data <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/acc_rd_channel.sv
// Fetches num_lines consecutive lines from memory into a line FIFO under credit
// control and hands them to the accelerator read port one per request.
module acc_rd_channel
    import acc_rd_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int LEN_WIDTH  = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  num_lines,
    output logic                  mem_rd_req_valid,
    input  logic                  mem_rd_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_rd_req_addr,
    input  logic                  mem_rd_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rd_resp_data,
    output logic                  acc_user_available_read,
    input  logic                  acc_user_request_read,
    output logic                  acc_user_read_data_valid,
    output logic [DATA_WIDTH-1:0] acc_user_read_data,
    output logic                  acc_user_done_rd_data,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned LINE_BYTES = line_bytes(DATA_WIDTH);
    localparam int unsigned AW         = log2_depth(FIFO_DEPTH);

    state_t                state;
    logic [ADDR_WIDTH-1:0] base;
    logic [LEN_WIDTH-1:0]  total;
    logic [LEN_WIDTH-1:0]  issued;
    logic [LEN_WIDTH-1:0]  received;
    logic [LEN_WIDTH-1:0]  delivered;
    logic [LEN_WIDTH-1:0]  outstanding;
    logic [LEN_WIDTH-1:0]  in_flight;
    logic [AW:0]           fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  req_fire;
    logic                  push;
    logic                  pop;

    // Credit covers buffered lines plus requests still in flight.
    assign outstanding      = issued - received;
    assign in_flight        = LEN_WIDTH'(fifo_count) + outstanding;
    assign mem_rd_req_valid = (state == RUN) && (issued < total)
                              && (in_flight < LEN_WIDTH'(FIFO_DEPTH));
    assign mem_rd_req_addr  = base + ADDR_WIDTH'(issued) * ADDR_WIDTH'(LINE_BYTES);
    assign req_fire         = mem_rd_req_valid && mem_rd_req_ready;

    assign push                    = mem_rd_resp_valid && (outstanding != '0) && !fifo_full;
    assign acc_user_available_read = !fifo_empty;
    assign pop                     = acc_user_request_read && acc_user_available_read;

    acc_rd_line_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (mem_rd_resp_data),
        .pop       (pop),
        .pop_data  (acc_user_read_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                    <= IDLE;
            base                     <= '0;
            total                    <= '0;
            issued                   <= '0;
            received                 <= '0;
            delivered                <= '0;
            acc_user_read_data_valid <= 1'b0;
            acc_user_done_rd_data    <= 1'b0;
            busy                     <= 1'b0;
            err                      <= 1'b0;
        end else begin
            acc_user_read_data_valid <= pop;
            if (mem_rd_resp_valid && (outstanding == '0)) err <= 1'b1;
            if (req_fire) issued    <= issued + 1'b1;
            if (push)     received  <= received + 1'b1;
            if (pop)      delivered <= delivered + 1'b1;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (num_lines != '0) begin
                            state                 <= RUN;
                            busy                  <= 1'b1;
                            acc_user_done_rd_data <= 1'b0;
                            base                  <= base_addr;
                            total                 <= num_lines;
                            issued                <= '0;
                            received              <= '0;
                            delivered             <= '0;
                        end else begin
                            state                 <= DONE;
                            acc_user_done_rd_data <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pop && (delivered + 1'b1 == total)) begin
                        state                 <= DONE;
                        busy                  <= 1'b0;
                        acc_user_done_rd_data <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_rd_channel.sv
// Scenario bench for acc_rd_channel: a memory responder and accelerator driver
// feed scoreboard queues that each scenario task checks inline.
`timescale 1ns/1ps
module tb_acc_rd_channel;

    localparam int DW = 512;
    localparam int AW = 64;
    localparam int LW = 32;
    localparam int FD = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] num_lines = '0;
    logic          mem_rd_req_valid;
    logic          mem_rd_req_ready = 1'b0;
    logic [AW-1:0] mem_rd_req_addr;
    logic          mem_rd_resp_valid;
    logic [DW-1:0] mem_rd_resp_data;
    logic          acc_user_available_read;
    logic          acc_user_request_read;
    logic          acc_user_read_data_valid;
    logic [DW-1:0] acc_user_read_data;
    logic          acc_user_done_rd_data;
    logic          busy;
    logic          err;

    acc_rd_channel #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .start                    (start),
        .base_addr                (base_addr),
        .num_lines                (num_lines),
        .mem_rd_req_valid         (mem_rd_req_valid),
        .mem_rd_req_ready         (mem_rd_req_ready),
        .mem_rd_req_addr          (mem_rd_req_addr),
        .mem_rd_resp_valid        (mem_rd_resp_valid),
        .mem_rd_resp_data         (mem_rd_resp_data),
        .acc_user_available_read  (acc_user_available_read),
        .acc_user_request_read    (acc_user_request_read),
        .acc_user_read_data_valid (acc_user_read_data_valid),
        .acc_user_read_data       (acc_user_read_data),
        .acc_user_done_rd_data    (acc_user_done_rd_data),
        .busy                     (busy),
        .err                      (err)
    );

    initial forever #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Written only by the responder process.
    logic [DW-1:0] exp_data[$];
    logic [DW-1:0] obs_data[$];
    logic [AW-1:0] obs_addr[$];
    logic [AW-1:0] pend_addr[$];
    int            pend_due[$];
    int            cyc = 0;
    int            inject_seen = 0;
    int            release_seen = 0;

    // Written only by the main sequence.
    logic auto_pop   = 1'b0;
    logic manual_req = 1'b0;
    logic resp_hold  = 1'b0;
    int   inject_cnt = 0;
    int   release_cnt = 0;
    int   exp_idx = 0;
    int   obs_idx = 0;

    function automatic logic [DW-1:0] line_of(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 64; i++)
            d[i*64 +: 64] = a ^ (64'h9E37_79B9_7F4A_7C15 * 64'(i + 1));
        return d;
    endfunction

    // Memory responder (2-cycle latency, in order) and accelerator read driver.
    initial begin
        logic [AW-1:0] a;
        mem_rd_resp_valid     = 1'b0;
        mem_rd_resp_data      = '0;
        acc_user_request_read = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (acc_user_read_data_valid) obs_data.push_back(acc_user_read_data);
            if (mem_rd_req_valid && mem_rd_req_ready) begin
                obs_addr.push_back(mem_rd_req_addr);
                pend_addr.push_back(mem_rd_req_addr);
                pend_due.push_back(cyc + 2);
            end
            mem_rd_resp_valid = 1'b0;
            if (inject_cnt != inject_seen) begin
                inject_seen++;
                mem_rd_resp_valid = 1'b1;
                mem_rd_resp_data  = line_of(64'hDEAD_BEEF_0000_0000);
            end else if (pend_addr.size() > 0 &&
                         ((release_cnt != release_seen) || (!resp_hold && pend_due[0] <= cyc))) begin
                if (release_cnt != release_seen) release_seen++;
                a = pend_addr.pop_front();
                void'(pend_due.pop_front());
                mem_rd_resp_valid = 1'b1;
                mem_rd_resp_data  = line_of(a);
                exp_data.push_back(line_of(a));
            end
            acc_user_request_read = auto_pop ? acc_user_available_read : manual_req;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_run(input logic [AW-1:0] b, input logic [LW-1:0] n);
        start     = 1'b1;
        base_addr = b;
        num_lines = n;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick(3);
        n_cmp++;
        if ({mem_rd_req_valid, acc_user_available_read, acc_user_read_data_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: req_valid/avail/rd_valid=%b want 000",
                     {mem_rd_req_valid, acc_user_available_read, acc_user_read_data_valid});
        end
        n_cmp++;
        if ({acc_user_done_rd_data, busy, err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_status: done/busy/err=%b want 000", {acc_user_done_rd_data, busy, err});
        end
        n_cmp++;
        if (acc_user_read_data !== '0) begin
            n_fail++;
            $display("FAIL reset_data: read_data=%h want 0", acc_user_read_data);
        end
        rst = 1'b1;
        tick(2);
        n_cmp++;
        if (busy !== 1'b0 || mem_rd_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b req_valid=%b want 0 0", busy, mem_rd_req_valid);
        end
    endtask

    task automatic test_zero_length;
        int a0;
        logic saw_busy;
        a0 = obs_addr.size();
        mem_rd_req_ready = 1'b1;
        start_run(64'h7000, 0);
        n_cmp++;
        if (acc_user_done_rd_data !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done: done=%b want 1", acc_user_done_rd_data);
        end
        saw_busy = busy;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw_busy = saw_busy | busy;
        end
        n_cmp++;
        if (saw_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_busy: busy seen=%b want 0", saw_busy);
        end
        n_cmp++;
        if (obs_addr.size() - a0 != 0) begin
            n_fail++;
            $display("FAIL zero_reqs: requests=%0d want 0", obs_addr.size() - a0);
        end
    endtask

    task automatic test_basic;
        int a0;
        int o0;
        logic [AW-1:0] b;
        b = 64'h1000;
        a0 = obs_addr.size();
        o0 = obs_data.size();
        resp_hold = 1'b0;
        auto_pop  = 1'b1;
        mem_rd_req_ready = 1'b1;
        start_run(b, 4);
        n_cmp++;
        if (acc_user_done_rd_data !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_start: done=%b busy=%b want 0 1", acc_user_done_rd_data, busy);
        end
        for (int i = 0; i < 200 && acc_user_done_rd_data !== 1'b1; i++) tick();
        n_cmp++;
        if (acc_user_done_rd_data !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done: done=%b after timeout want 1", acc_user_done_rd_data);
        end
        n_cmp++;
        if (acc_user_read_data_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_timing: rd_valid=%b busy=%b want 1 0", acc_user_read_data_valid, busy);
        end
        tick(2);
        n_cmp++;
        if (obs_addr.size() - a0 != 4 || obs_data.size() - o0 != 4) begin
            n_fail++;
            $display("FAIL basic_counts: reqs=%0d pops=%0d want 4 4", obs_addr.size() - a0, obs_data.size() - o0);
        end
        for (int i = 0; i < 4 && a0 + i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[a0 + i] !== b + 64'(i) * 64'd64) begin
                n_fail++;
                $display("FAIL basic_addr[%0d]: got %h want %h", i, obs_addr[a0 + i], b + 64'(i) * 64'd64);
            end
        end
        while (obs_idx < obs_data.size() && exp_idx < exp_data.size()) begin
            n_cmp++;
            if (obs_data[obs_idx] !== exp_data[exp_idx]) begin
                n_fail++;
                $display("FAIL basic_data[%0d]: got %h want %h", obs_idx, obs_data[obs_idx], exp_data[exp_idx]);
            end
            obs_idx++;
            exp_idx++;
        end
    endtask

    task automatic test_backpressure;
        int a0;
        int o0;
        logic [AW-1:0] b;
        b = 64'h2000;
        a0 = obs_addr.size();
        o0 = obs_data.size();
        auto_pop   = 1'b0;
        manual_req = 1'b0;
        start_run(b, 20);
        tick(30);
        n_cmp++;
        if (obs_addr.size() - a0 != FD || mem_rd_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_fill: reqs=%0d req_valid=%b want %0d 0", obs_addr.size() - a0, mem_rd_req_valid, FD);
        end
        manual_req = 1'b1;
        tick(3);
        manual_req = 1'b0;
        tick(20);
        n_cmp++;
        if (obs_data.size() - o0 != 3) begin
            n_fail++;
            $display("FAIL credit_pops: pops=%0d want 3", obs_data.size() - o0);
        end
        n_cmp++;
        if (obs_addr.size() - a0 != FD + 3 || mem_rd_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_refill: reqs=%0d req_valid=%b want %0d 0", obs_addr.size() - a0, mem_rd_req_valid, FD + 3);
        end
        auto_pop = 1'b1;
        for (int i = 0; i < 400 && acc_user_done_rd_data !== 1'b1; i++) tick();
        n_cmp++;
        if (acc_user_done_rd_data !== 1'b1) begin
            n_fail++;
            $display("FAIL credit_done: done=%b after timeout want 1", acc_user_done_rd_data);
        end
        tick(2);
        n_cmp++;
        if (obs_addr.size() - a0 != 20 || obs_data.size() - o0 != 20) begin
            n_fail++;
            $display("FAIL credit_counts: reqs=%0d pops=%0d want 20 20", obs_addr.size() - a0, obs_data.size() - o0);
        end
        for (int i = 0; i < 20 && a0 + i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[a0 + i] !== b + 64'(i) * 64'd64) begin
                n_fail++;
                $display("FAIL credit_addr[%0d]: got %h want %h", i, obs_addr[a0 + i], b + 64'(i) * 64'd64);
            end
        end
        while (obs_idx < obs_data.size() && exp_idx < exp_data.size()) begin
            n_cmp++;
            if (obs_data[obs_idx] !== exp_data[exp_idx]) begin
                n_fail++;
                $display("FAIL credit_data[%0d]: got %h want %h", obs_idx, obs_data[obs_idx], exp_data[exp_idx]);
            end
            obs_idx++;
            exp_idx++;
        end
    endtask

    task automatic test_stall_spurious;
        int a0;
        logic [AW-1:0] b;
        b = 64'h3000;
        a0 = obs_addr.size();
        auto_pop   = 1'b0;
        manual_req = 1'b1;
        mem_rd_req_ready = 1'b0;
        start_run(b, 2);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (mem_rd_req_valid !== 1'b1 || mem_rd_req_addr !== b) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: valid=%b addr=%h want 1 %h", i, mem_rd_req_valid, mem_rd_req_addr, b);
            end
            n_cmp++;
            if (acc_user_read_data_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL spurious_read[%0d]: rd_valid=%b want 0", i, acc_user_read_data_valid);
            end
            tick();
        end
        manual_req = 1'b0;
        mem_rd_req_ready = 1'b1;
        auto_pop = 1'b1;
        for (int i = 0; i < 100 && acc_user_done_rd_data !== 1'b1; i++) tick();
        tick(2);
        n_cmp++;
        if (acc_user_done_rd_data !== 1'b1 || obs_addr.size() - a0 != 2) begin
            n_fail++;
            $display("FAIL stall_finish: done=%b reqs=%0d want 1 2", acc_user_done_rd_data, obs_addr.size() - a0);
        end
        for (int i = 0; i < 2 && a0 + i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[a0 + i] !== b + 64'(i) * 64'd64) begin
                n_fail++;
                $display("FAIL stall_addr[%0d]: got %h want %h", i, obs_addr[a0 + i], b + 64'(i) * 64'd64);
            end
        end
        while (obs_idx < obs_data.size() && exp_idx < exp_data.size()) begin
            n_cmp++;
            if (obs_data[obs_idx] !== exp_data[exp_idx]) begin
                n_fail++;
                $display("FAIL stall_data[%0d]: got %h want %h", obs_idx, obs_data[obs_idx], exp_data[exp_idx]);
            end
            obs_idx++;
            exp_idx++;
        end
        auto_pop = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        inject_cnt++;
        tick(3);
        n_cmp++;
        if (err !== 1'b1 || acc_user_available_read !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_resp: err=%b avail=%b want 1 0", err, acc_user_available_read);
        end
    endtask

    task automatic test_push_pop_restart;
        int a0;
        logic [AW-1:0] b;
        b = 64'h4000;
        a0 = obs_addr.size();
        resp_hold  = 1'b1;
        auto_pop   = 1'b0;
        manual_req = 1'b0;
        start_run(b, 2);
        tick(4);
        n_cmp++;
        if (obs_addr.size() - a0 != 2) begin
            n_fail++;
            $display("FAIL pp_reqs: reqs=%0d want 2", obs_addr.size() - a0);
        end
        release_cnt++;
        tick(2);
        n_cmp++;
        if (acc_user_available_read !== 1'b1) begin
            n_fail++;
            $display("FAIL pp_one_line: avail=%b want 1", acc_user_available_read);
        end
        release_cnt++;
        manual_req = 1'b1;
        tick();
        manual_req = 1'b0;
        n_cmp++;
        if (acc_user_available_read !== 1'b1 || acc_user_read_data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pp_same_cycle: avail=%b rd_valid=%b want 1 1", acc_user_available_read, acc_user_read_data_valid);
        end
        tick();
        manual_req = 1'b1;
        tick();
        manual_req = 1'b0;
        n_cmp++;
        if (acc_user_done_rd_data !== 1'b1 || acc_user_read_data_valid !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_done: done=%b rd_valid=%b busy=%b want 1 1 0",
                     acc_user_done_rd_data, acc_user_read_data_valid, busy);
        end
        tick(2);
        resp_hold = 1'b0;
        auto_pop  = 1'b1;
        b = 64'hFFFF_FFFF_FFFF_FFC0;
        a0 = obs_addr.size();
        start_run(b, 2);
        n_cmp++;
        if (acc_user_done_rd_data !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_start: done=%b want 0", acc_user_done_rd_data);
        end
        for (int i = 0; i < 100 && acc_user_done_rd_data !== 1'b1; i++) tick();
        tick(2);
        n_cmp++;
        if (acc_user_done_rd_data !== 1'b1 || obs_addr.size() - a0 != 2) begin
            n_fail++;
            $display("FAIL wrap_finish: done=%b reqs=%0d want 1 2", acc_user_done_rd_data, obs_addr.size() - a0);
        end
        for (int i = 0; i < 2 && a0 + i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[a0 + i] !== b + 64'(i) * 64'd64) begin
                n_fail++;
                $display("FAIL wrap_addr[%0d]: got %h want %h", i, obs_addr[a0 + i], b + 64'(i) * 64'd64);
            end
        end
        while (obs_idx < obs_data.size() && exp_idx < exp_data.size()) begin
            n_cmp++;
            if (obs_data[obs_idx] !== exp_data[exp_idx]) begin
                n_fail++;
                $display("FAIL pp_data[%0d]: got %h want %h", obs_idx, obs_data[obs_idx], exp_data[exp_idx]);
            end
            obs_idx++;
            exp_idx++;
        end
    endtask

    task automatic test_reset_mid_run;
        int a0;
        logic [AW-1:0] b;
        auto_pop   = 1'b0;
        manual_req = 1'b0;
        a0 = obs_addr.size();
        start_run(64'h5000, 3);
        tick(10);
        n_cmp++;
        if (acc_user_available_read !== 1'b1 || busy !== 1'b1 || obs_addr.size() - a0 != 3) begin
            n_fail++;
            $display("FAIL mid_pre: avail=%b busy=%b reqs=%0d want 1 1 3",
                     acc_user_available_read, busy, obs_addr.size() - a0);
        end
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({acc_user_available_read, acc_user_done_rd_data, busy, mem_rd_req_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_async: avail/done/busy/req_valid=%b want 0000",
                     {acc_user_available_read, acc_user_done_rd_data, busy, mem_rd_req_valid});
        end
        tick(2);
        rst = 1'b1;
        tick();
        exp_idx = exp_data.size();
        obs_idx = obs_data.size();
        n_cmp++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_err_clear: err=%b want 0", err);
        end
        b = 64'h6000;
        a0 = obs_addr.size();
        auto_pop = 1'b1;
        start_run(b, 2);
        for (int i = 0; i < 100 && acc_user_done_rd_data !== 1'b1; i++) tick();
        tick(2);
        n_cmp++;
        if (acc_user_done_rd_data !== 1'b1 || err !== 1'b0 || obs_data.size() - obs_idx != 2) begin
            n_fail++;
            $display("FAIL mid_rerun: done=%b err=%b pops=%0d want 1 0 2",
                     acc_user_done_rd_data, err, obs_data.size() - obs_idx);
        end
        for (int i = 0; i < 2 && a0 + i < obs_addr.size(); i++) begin
            n_cmp++;
            if (obs_addr[a0 + i] !== b + 64'(i) * 64'd64) begin
                n_fail++;
                $display("FAIL mid_addr[%0d]: got %h want %h", i, obs_addr[a0 + i], b + 64'(i) * 64'd64);
            end
        end
        while (obs_idx < obs_data.size() && exp_idx < exp_data.size()) begin
            n_cmp++;
            if (obs_data[obs_idx] !== exp_data[exp_idx]) begin
                n_fail++;
                $display("FAIL mid_data[%0d]: got %h want %h", obs_idx, obs_data[obs_idx], exp_data[exp_idx]);
            end
            obs_idx++;
            exp_idx++;
        end
    endtask

    initial begin
        test_reset();
        test_zero_length();
        test_basic();
        test_backpressure();
        test_stall_spurious();
        test_push_pop_restart();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
